// File: rtl/datapath_pkg.sv
// datapath_pkg: shared types and default widths for the pipelined datapath.
//   alu_op_e      - 3-bit ALU operation code
//   *_DEF         - default parameter values for DATA_W, REG_AW, MEM_AW
//   ex_ctl_t      - width-independent control fields of the EX pipeline register
//   wb_ctl_t      - width-independent control fields of the WB pipeline register
// Width-dependent pipeline structs wrap these inside datapath_pipe, where the
// parameters are known.
package datapath_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int REG_AW_DEF = 4;
    localparam int MEM_AW_DEF = 8;

    typedef enum logic [2:0] {
        ALU_ZERO   = 3'b000,
        ALU_ADD    = 3'b001,
        ALU_SUB    = 3'b010,
        ALU_PASS_A = 3'b011,
        ALU_XOR    = 3'b100,
        ALU_OR     = 3'b101,
        ALU_AND    = 3'b110,
        ALU_INC    = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic    valid;
        logic    d_we;
        logic    mux_s;
        logic    w_en;
        alu_op_e alu_s;
    } ex_ctl_t;

    typedef struct packed {
        logic valid;
        logic mux_s;
        logic w_en;
    } wb_ctl_t;

endpackage

// File: rtl/dp_alu.sv
// dp_alu: combinational ALU, results wrap modulo 2**DATA_W.
//   a, b : operands
//   op   : operation (alu_op_e)
//   y    : result
module dp_alu
    import datapath_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_e           op,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            ALU_ZERO:   y = '0;
            ALU_ADD:    y = a + b;
            ALU_SUB:    y = a - b;
            ALU_PASS_A: y = a;
            ALU_XOR:    y = a ^ b;
            ALU_OR:     y = a | b;
            ALU_AND:    y = a & b;
            ALU_INC:    y = a + DATA_W'(1);
            default:    y = '0;
        endcase
    end

endmodule

// File: rtl/datapath_pipe.sv
// datapath_pipe: two-stage (EX, WB) pipelined datapath with register file,
// ALU, synchronous data memory and write-back select.
//   clk, rst_n          - clock / async active-low reset
//   in_valid, in_ready  - micro-op handshake (in_ready = !hold)
//   d_addr, d_we        - data-memory address / store enable (stores operand B)
//   mux_s               - write-back select: 1 = memory read data, 0 = ALU result
//   w_addr, w_en        - register-file write address / enable
//   ra_addr, rb_addr    - operand read addresses
//   alu_s               - ALU operation
//   hold                - downstream stall, freezes EX and WB
//   alu_a, alu_b        - EX operands after forwarding (0 when EX is empty)
//   alu_out             - EX ALU result (0 when EX is empty)
//   res_valid, res_data - WB result
module datapath_pipe
    import datapath_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int MEM_AW = MEM_AW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MEM_AW-1:0] d_addr,
    input  logic              d_we,
    input  logic              mux_s,
    input  logic [REG_AW-1:0] w_addr,
    input  logic              w_en,
    input  logic [REG_AW-1:0] ra_addr,
    input  logic [REG_AW-1:0] rb_addr,
    input  logic [2:0]        alu_s,
    input  logic              hold,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [DATA_W-1:0] alu_out,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data
);

    localparam int N_REGS  = 2 ** REG_AW;
    localparam int N_WORDS = 2 ** MEM_AW;

    typedef struct packed {
        ex_ctl_t           ctl;
        logic [MEM_AW-1:0] d_addr;
        logic [REG_AW-1:0] w_addr;
        logic [REG_AW-1:0] ra_addr;
        logic [REG_AW-1:0] rb_addr;
    } ex_reg_t;

    typedef struct packed {
        wb_ctl_t           ctl;
        logic [REG_AW-1:0] w_addr;
        logic [DATA_W-1:0] alu_res;
    } wb_reg_t;

    logic [DATA_W-1:0] rf  [N_REGS];
    logic [DATA_W-1:0] mem [N_WORDS];

    ex_reg_t           ex_q, ex_d;
    wb_reg_t           wb_q, wb_d;
    logic [DATA_W-1:0] mem_q;
    logic [DATA_W-1:0] op_a, op_b, alu_y;
    logic              fwd_a, fwd_b, wb_write;

    assign in_ready = ~hold;

    // WB result forwarded into EX whenever WB is about to write the register EX reads.
    assign wb_write = wb_q.ctl.valid && wb_q.ctl.w_en;
    assign fwd_a    = wb_write && (wb_q.w_addr == ex_q.ra_addr);
    assign fwd_b    = wb_write && (wb_q.w_addr == ex_q.rb_addr);
    assign op_a     = fwd_a ? res_data : rf[ex_q.ra_addr];
    assign op_b     = fwd_b ? res_data : rf[ex_q.rb_addr];

    dp_alu #(.DATA_W(DATA_W)) u_alu (
        .a  (op_a),
        .b  (op_b),
        .op (ex_q.ctl.alu_s),
        .y  (alu_y)
    );

    assign alu_a   = ex_q.ctl.valid ? op_a  : '0;
    assign alu_b   = ex_q.ctl.valid ? op_b  : '0;
    assign alu_out = ex_q.ctl.valid ? alu_y : '0;

    assign res_valid = wb_q.ctl.valid;
    assign res_data  = wb_q.ctl.mux_s ? mem_q : wb_q.alu_res;

    always_comb begin
        ex_d             = '0;
        ex_d.ctl.valid   = in_valid;
        ex_d.ctl.d_we    = d_we;
        ex_d.ctl.mux_s   = mux_s;
        ex_d.ctl.w_en    = w_en;
        ex_d.ctl.alu_s   = alu_op_e'(alu_s);
        ex_d.d_addr      = d_addr;
        ex_d.w_addr      = w_addr;
        ex_d.ra_addr     = ra_addr;
        ex_d.rb_addr     = rb_addr;

        wb_d             = '0;
        wb_d.ctl.valid   = ex_q.ctl.valid;
        wb_d.ctl.mux_s   = ex_q.ctl.mux_s;
        wb_d.ctl.w_en    = ex_q.ctl.w_en;
        wb_d.w_addr      = ex_q.w_addr;
        wb_d.alu_res     = alu_out;
    end

    // Pipeline registers and the memory read register all freeze under hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            wb_q  <= '0;
            mem_q <= '0;
        end else if (!hold) begin
            ex_q <= ex_d;
            wb_q <= wb_d;
            if (ex_q.ctl.valid) begin
                mem_q <= mem[ex_q.d_addr];
            end
        end
    end

    // Memory is not reset; the read above sees the pre-store contents on
    // a same-address read-during-write.
    always_ff @(posedge clk) begin
        if (rst_n && !hold && ex_q.ctl.valid && ex_q.ctl.d_we) begin
            mem[ex_q.d_addr] <= op_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REGS; i++) begin
                rf[i] <= '0;
            end
        end else if (!hold && wb_write) begin
            rf[wb_q.w_addr] <= res_data;
        end
    end

endmodule

// File: tb/tb_datapath_pipe.sv
module tb_datapath_pipe;
    import datapath_pkg::*;

    localparam int DW  = 16;
    localparam int RAW = 4;
    localparam int MAW = 8;

    localparam logic [2:0] OP_ZERO = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_PASS = 3'b011;
    localparam logic [2:0] OP_INC  = 3'b111;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [MAW-1:0] d_addr = '0;
    logic           d_we = 1'b0;
    logic           mux_s = 1'b0;
    logic [RAW-1:0] w_addr = '0;
    logic           w_en = 1'b0;
    logic [RAW-1:0] ra_addr = '0;
    logic [RAW-1:0] rb_addr = '0;
    logic [2:0]     alu_s = '0;
    logic           hold = 1'b0;
    logic [DW-1:0]  alu_a, alu_b, alu_out;
    logic           res_valid;
    logic [DW-1:0]  res_data;

    always #5 clk = ~clk;

    datapath_pipe #(.DATA_W(DW), .REG_AW(RAW), .MEM_AW(MAW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d_addr    (d_addr),
        .d_we      (d_we),
        .mux_s     (mux_s),
        .w_addr    (w_addr),
        .w_en      (w_en),
        .ra_addr   (ra_addr),
        .rb_addr   (rb_addr),
        .alu_s     (alu_s),
        .hold      (hold),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_out   (alu_out),
        .res_valid (res_valid),
        .res_data  (res_data)
    );

    int            vectors = 0;
    int            miscompares = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] m_rf  [16];
    logic [DW-1:0] m_mem [256];

    function automatic logic [DW-1:0] m_alu(logic [2:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
        case (op)
            3'd0: return '0;
            3'd1: return a + b;
            3'd2: return a - b;
            3'd3: return a;
            3'd4: return a ^ b;
            3'd5: return a | b;
            3'd6: return a & b;
            default: return a + 16'd1;
        endcase
    endfunction

    task automatic check(string tag, logic [DW-1:0] obs, logic [DW-1:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Compare the WB result at the negedge of the cycle in which it is consumed.
    task automatic step();
        @(negedge clk);
        if (rst_n && res_valid && !hold) begin
            if (exp_q.size() == 0) check("sb_empty", DW'(exp_q.size()), DW'(1));
            else check("sb_res", res_data, exp_q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(bit v, logic [2:0] op, logic [3:0] ra, logic [3:0] rb, logic [3:0] wa,
                         bit we, bit ms, bit dwe, logic [7:0] da);
        logic [DW-1:0] a, b, r;
        in_valid = v; alu_s = op; ra_addr = ra; rb_addr = rb; w_addr = wa;
        w_en = we; mux_s = ms; d_we = dwe; d_addr = da;
        if (v && !hold) begin
            a = m_rf[ra];
            b = m_rf[rb];
            r = ms ? m_mem[da] : m_alu(op, a, b);
            if (dwe) m_mem[da] = b;
            if (we)  m_rf[wa]  = r;
            exp_q.push_back(r);
        end
        step();
    endtask

    task automatic idle();
        issue(1'b0, OP_ZERO, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) m_rf[i] = '0;

        // Reset state
        #12;
        check("rst_res_valid", DW'(res_valid), DW'(0));
        check("rst_res_data", res_data, 16'h0000);
        check("rst_alu_a", alu_a, 16'h0000);
        check("rst_alu_b", alu_b, 16'h0000);
        check("rst_alu_out", alu_out, 16'h0000);
        check("rst_in_ready", DW'(in_ready), DW'(1));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Back-to-back dependent chain r1=r0, r2=r1+1, r3=r2+1
        issue(1, OP_PASS, 4'd0, 4'd0, 4'd1, 1, 0, 0, 8'h00);
        issue(1, OP_INC,  4'd1, 4'd0, 4'd2, 1, 0, 0, 8'h00);
        check("fwd1_alu_a", alu_a, 16'd0);
        check("fwd1_alu_out", alu_out, 16'd1);
        issue(1, OP_INC,  4'd2, 4'd0, 4'd3, 1, 0, 0, 8'h00);
        check("fwd2_alu_out", alu_out, 16'd2);

        // r4 = 5, store to 0x10, load into r5
        issue(1, OP_INC,  4'd3, 4'd0, 4'd4, 1, 0, 0, 8'h00);
        issue(1, OP_INC,  4'd4, 4'd0, 4'd4, 1, 0, 0, 8'h00);
        issue(1, OP_INC,  4'd4, 4'd0, 4'd4, 1, 0, 0, 8'h00);
        issue(1, OP_ZERO, 4'd0, 4'd4, 4'd0, 0, 0, 1, 8'h10);
        check("store_alu_b", alu_b, 16'd5);
        issue(1, OP_ZERO, 4'd0, 4'd0, 4'd5, 1, 1, 0, 8'h10);

        // Load-use: r6 = r5 + r5
        issue(1, OP_ADD,  4'd5, 4'd5, 4'd6, 1, 0, 0, 8'h00);
        check("ldu_alu_a", alu_a, 16'd5);
        check("ldu_alu_b", alu_b, 16'd5);
        check("ldu_alu_out", alu_out, 16'd10);
        idle();
        check("ldu_res_data", res_data, 16'd10);

        // Read-during-write on 0x10 returns old data, then reload sees new data
        issue(1, OP_ZERO, 4'd0, 4'd6, 4'd12, 1, 1, 1, 8'h10);
        issue(1, OP_ZERO, 4'd0, 4'd0, 4'd13, 1, 1, 0, 8'h10);

        // Hold with r8 write in WB and a store in EX
        issue(1, OP_INC,  4'd4, 4'd0, 4'd8, 1, 0, 0, 8'h00);
        issue(1, OP_ADD,  4'd8, 4'd8, 4'd9, 1, 0, 1, 8'h20);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue(1, OP_INC, 4'd8, 4'd8, 4'd10, 1, 0, 0, 8'h00);
            check("hold_in_ready", DW'(in_ready), DW'(0));
            check("hold_res_valid", DW'(res_valid), DW'(1));
            check("hold_res_data", res_data, 16'd6);
            check("hold_alu_b", alu_b, 16'd6);
        end
        hold = 1'b0;
        issue(1, OP_PASS, 4'd8, 4'd0, 4'd10, 1, 0, 0, 8'h00);
        issue(1, OP_ZERO, 4'd0, 4'd0, 4'd11, 1, 1, 0, 8'h20);
        issue(1, OP_ADD,  4'd9, 4'd0, 4'd14, 1, 0, 0, 8'h00);

        // Wrap: r7 = 0 - 1, then r7 + 1
        issue(1, OP_SUB,  4'd0, 4'd2, 4'd7, 1, 0, 0, 8'h00);
        issue(1, OP_INC,  4'd7, 4'd0, 4'd7, 1, 0, 0, 8'h00);
        check("wrap_alu_a", alu_a, 16'hFFFF);
        check("wrap_alu_out", alu_out, 16'h0000);
        idle();
        check("wrap_res_data", res_data, 16'h0000);

        // Mid-stream reset with ops in EX and WB
        issue(1, OP_PASS, 4'd4, 4'd0, 4'd15, 1, 0, 0, 8'h00);
        issue(1, OP_INC,  4'd15, 4'd0, 4'd1, 1, 0, 0, 8'h00);
        rst_n = 1'b0;
        #1;
        check("mrst_res_valid", DW'(res_valid), DW'(0));
        check("mrst_res_data", res_data, 16'h0000);
        check("mrst_alu_out", alu_out, 16'h0000);
        exp_q.delete();
        for (int i = 0; i < 16; i++) m_rf[i] = '0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            issue(1, OP_PASS, 4'(i), 4'd0, 4'd0, 0, 0, 0, 8'h00);
        end
        for (int i = 0; i < 3; i++) idle();
        check("sb_drained", DW'(exp_q.size()), DW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
